// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the AXI side and the AES engine.
// Latency: grant at edge N, BRAM strobe visible from N+1, write done from N+2, read done and rdata from N+3.
// Backpressure: the owner keeps done high until its req is sampled low; the loser keeps req high to wait.
module bram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              axi_clk,
   input  logic              axi_rst,
   // AXI-side requester
   input  logic              axi_req,
   input  logic              axi_we,
   input  logic [ADDR_W-1:0] axi_addr,
   input  logic [DATA_W-1:0] axi_wdata,
   output logic [DATA_W-1:0] axi_rdata,
   output logic              axi_done,
   // AES-engine requester
   input  logic              aes_req,
   input  logic              aes_we,
   input  logic [ADDR_W-1:0] aes_addr,
   input  logic [DATA_W-1:0] aes_wdata,
   output logic [DATA_W-1:0] aes_rdata,
   output logic              aes_done,
   // BRAM port (same clock as axi_clk)
   output logic [ADDR_W-1:0] addr_BRAM,
   output logic [DATA_W-1:0] dout_BRAM,
   input  logic [DATA_W-1:0] din_BRAM,
   output logic              en_BRAM,
   output logic [3:0]        we_BRAM,
   // status
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RDWAIT  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // last_owner remembers who was granted most recently; owner is the visible copy
   logic              last_owner;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              grant_vld;
   logic              grant_sel;
   logic              owner_req;
   logic              owner_done;

   logic              en_nxt;
   logic [3:0]        we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] dout_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              rd_capture;
   logic              owner_nxt;
   logic [DATA_W-1:0] axi_rdata_nxt;
   logic [DATA_W-1:0] aes_rdata_nxt;

   // Arbitration: a lone request wins; a tie goes to whoever was not served last
   always_comb begin
      grant_vld  = (state == IDLE) && (axi_req || aes_req);
      grant_sel  = (axi_req && aes_req) ? ~last_owner : aes_req;
      owner_req  = owner ? aes_req  : axi_req;
      owner_done = owner ? aes_done : axi_done;
   end

   // State register
   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; RELEASE only exits once done has been visible for a cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = ACCESS;
         ACCESS:  state_nxt = lat_we ? RELEASE : RDWAIT;
         RDWAIT:  state_nxt = RELEASE;
         RELEASE: if (owner_done && !owner_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode. Outputs are registered, so each state's outputs appear one edge later;
   // the BRAM strobe issued from ACCESS returns data while the FSM sits in its first RELEASE cycle,
   // which is when that data is captured (the same edge that raises done).
   always_comb begin
      en_nxt        = (state == ACCESS);
      we_nxt        = ((state == ACCESS) && lat_we) ? 4'hF : 4'h0;
      addr_nxt      = (state == ACCESS) ? lat_addr  : addr_BRAM;
      dout_nxt      = (state == ACCESS) ? lat_wdata : dout_BRAM;
      busy_nxt      = (state_nxt != IDLE);
      done_nxt      = (state == RELEASE) && (state_nxt == RELEASE);
      rd_capture    = (state == RELEASE) && !owner_done && !lat_we;
      owner_nxt     = grant_vld ? grant_sel : owner;
      axi_rdata_nxt = (rd_capture && !owner) ? din_BRAM : axi_rdata;
      aes_rdata_nxt = (rd_capture &&  owner) ? din_BRAM : aes_rdata;
   end

   // Output registers; reset drops every output, including an in-flight BRAM strobe
   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         en_BRAM   <= 1'b0;
         we_BRAM   <= 4'h0;
         addr_BRAM <= '0;
         dout_BRAM <= '0;
         busy      <= 1'b0;
         owner     <= 1'b0;
         axi_done  <= 1'b0;
         aes_done  <= 1'b0;
         axi_rdata <= '0;
         aes_rdata <= '0;
      end else begin
         en_BRAM   <= en_nxt;
         we_BRAM   <= we_nxt;
         addr_BRAM <= addr_nxt;
         dout_BRAM <= dout_nxt;
         busy      <= busy_nxt;
         owner     <= owner_nxt;
         axi_done  <= done_nxt && !owner;
         aes_done  <= done_nxt &&  owner;
         axi_rdata <= axi_rdata_nxt;
         aes_rdata <= aes_rdata_nxt;
      end
   end

   // Grant latch: the winner's command is frozen so later input changes are ignored
   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         last_owner <= 1'b1;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else if (grant_vld) begin
         last_owner <= grant_sel;
         lat_we     <= grant_sel ? aes_we    : axi_we;
         lat_addr   <= grant_sel ? aes_addr  : axi_addr;
         lat_wdata  <= grant_sel ? aes_wdata : axi_wdata;
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus randomized two-requester traffic.
// A transaction-level model (cycles since grant, shadow memory) predicts every output each cycle.
// A behavioural BRAM with one-cycle read latency sits on the BRAM port.
module tb_bram_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              axi_clk = 1'b0;
   logic              axi_rst;
   logic              axi_req, axi_we;
   logic [ADDR_W-1:0] axi_addr;
   logic [DATA_W-1:0] axi_wdata, axi_rdata;
   logic              axi_done;
   logic              aes_req, aes_we;
   logic [ADDR_W-1:0] aes_addr;
   logic [DATA_W-1:0] aes_wdata, aes_rdata;
   logic              aes_done;
   logic [ADDR_W-1:0] addr_BRAM;
   logic [DATA_W-1:0] dout_BRAM, din_BRAM;
   logic              en_BRAM;
   logic [3:0]        we_BRAM;
   logic              busy, owner;

   int checks = 0;
   int errors = 0;

   always #5 axi_clk = ~axi_clk;

   bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst),
      .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
      .axi_rdata(axi_rdata), .axi_done(axi_done),
      .aes_req(aes_req), .aes_we(aes_we), .aes_addr(aes_addr), .aes_wdata(aes_wdata),
      .aes_rdata(aes_rdata), .aes_done(aes_done),
      .addr_BRAM(addr_BRAM), .dout_BRAM(dout_BRAM), .din_BRAM(din_BRAM),
      .en_BRAM(en_BRAM), .we_BRAM(we_BRAM), .busy(busy), .owner(owner)
   );

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] iv;
      iv = i;
      return (iv * 32'h9E3779B9) ^ 32'h5A5A0F0F;
   endfunction

   // Behavioural BRAM: one-cycle read latency, all-or-nothing write
   logic [DATA_W-1:0] bram_mem [256];
   bit                bram_init_done;
   always @(posedge axi_clk) begin
      if (!bram_init_done) begin
         for (int i = 0; i < 256; i++) bram_mem[i] <= init_word(i);
         bram_init_done <= 1'b1;
      end else if (en_BRAM) begin
         if (we_BRAM == 4'hF) bram_mem[addr_BRAM[7:0]] <= dout_BRAM;
         din_BRAM <= bram_mem[addr_BRAM[7:0]];
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [256];
   bit                m_busy, m_own, m_last, m_we;
   int                m_t;
   logic [ADDR_W-1:0] m_addr, e_addr;
   logic [DATA_W-1:0] m_wdata, e_dout;
   logic [DATA_W-1:0] e_rdata [2];

   // Agent state for the random phase
   int ph [2];
   int cool [2];
   int wcnt [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one step per rising edge, from the rules (grant, cycles since grant, release on req low)
   task automatic model_step();
      int   dstart;
      logic oreq;
      if (!axi_rst) begin
         m_busy = 0; m_own = 0; m_last = 1; m_t = 0;
         e_addr = '0; e_dout = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      end else if (!m_busy) begin
         if (axi_req || aes_req) begin
            m_own   = (axi_req && aes_req) ? !m_last : aes_req;
            m_last  = m_own;
            m_busy  = 1;
            m_t     = 0;
            m_we    = m_own ? aes_we    : axi_we;
            m_addr  = m_own ? aes_addr  : axi_addr;
            m_wdata = m_own ? aes_wdata : axi_wdata;
         end
      end else begin
         dstart = m_we ? 2 : 3;
         oreq   = m_own ? aes_req : axi_req;
         if (m_t == dstart) begin
            if (!oreq) m_busy = 0;
         end else begin
            m_t++;
            if (m_t == 1) begin
               e_addr = m_addr;
               e_dout = m_wdata;
               if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
            end
            if (m_t == dstart && !m_we) e_rdata[m_own] = ref_mem[m_addr[7:0]];
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] x_rd0, x_rd1, x_addr, x_dout, x_d0, x_d1, x_en, x_we, x_busy, x_own;
      int dstart;
      if (!axi_rst) begin
         x_rd0 = '0; x_rd1 = '0; x_addr = '0; x_dout = '0; x_d0 = '0;
         x_d1 = '0; x_en = '0; x_we = '0; x_busy = '0; x_own = '0;
      end else begin
         dstart = m_we ? 2 : 3;
         x_rd0  = e_rdata[0];
         x_rd1  = e_rdata[1];
         x_addr = e_addr;
         x_dout = e_dout;
         x_en   = (m_busy && m_t == 1) ? 32'd1 : 32'd0;
         x_we   = (m_busy && m_t == 1 && m_we) ? 32'hF : 32'd0;
         x_d0   = (m_busy && !m_own && m_t == dstart) ? 32'd1 : 32'd0;
         x_d1   = (m_busy &&  m_own && m_t == dstart) ? 32'd1 : 32'd0;
         x_busy = m_busy ? 32'd1 : 32'd0;
         x_own  = m_own  ? 32'd1 : 32'd0;
      end
      chk("axi_rdata", axi_rdata, x_rd0);
      chk("aes_rdata", aes_rdata, x_rd1);
      chk("axi_done", 32'(axi_done), x_d0);
      chk("aes_done", 32'(aes_done), x_d1);
      chk("addr_BRAM", addr_BRAM, x_addr);
      chk("dout_BRAM", dout_BRAM, x_dout);
      chk("en_BRAM", 32'(en_BRAM), x_en);
      chk("we_BRAM", 32'(we_BRAM), x_we);
      chk("busy", 32'(busy), x_busy);
      chk("owner", 32'(owner), x_own);
   endtask

   // One clock: model steps on the rising edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge axi_clk);
      model_step();
      @(negedge axi_clk);
      compare_all();
   endtask

   task automatic set_side(input bit s, input logic req, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (s) begin
         aes_req = req; aes_we = we; aes_addr = a; aes_wdata = d;
      end else begin
         axi_req = req; axi_we = we; axi_addr = a; axi_wdata = d;
      end
   endtask

   task automatic set_req(input bit s, input logic v);
      if (s) aes_req = v;
      else   axi_req = v;
   endtask

   task automatic wait_done(input bit s);
      int n = 0;
      while (!(s ? aes_done : axi_done)) begin
         if (n == 12) begin
            checks++; errors++;
            $display("FAIL wait_done side %0d: done=0 after %0d cycles, expected 1", s, n);
            return;
         end
         cycle();
         n++;
      end
   endtask

   task automatic wait_busy();
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!busy && n < 8);
      if (!busy) begin
         checks++; errors++;
         $display("FAIL wait_busy: busy=0 after %0d cycles, expected 1", n);
      end
   endtask

   // Full transaction: request, hold until done, drop, let the FSM return to IDLE
   task automatic do_txn(input bit s, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      set_side(s, 1'b1, we, a, d);
      wait_done(s);
      set_req(s, 1'b0);
      cycle();
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(63));
      return a;
   endfunction

   task automatic agent_step(input bit s);
      logic my_done, my_req;
      my_done = s ? aes_done : axi_done;
      my_req  = s ? aes_req  : axi_req;
      case (ph[s])
         0: begin
            if (cool[s] > 0) cool[s]--;
            else if ($urandom_range(2) == 0) begin
               set_side(s, 1'b1, 1'($urandom_range(1)), rand_addr(), $urandom());
               ph[s] = 1; wcnt[s] = 0;
            end
         end
         1: begin
            if (busy && (owner == s)) begin
               ph[s] = 2; wcnt[s] = 0;
               // scramble the command after the grant; sometimes drop req early
               set_side(s, 1'($urandom_range(2) != 0), 1'($urandom_range(1)), rand_addr(), $urandom());
            end else if (++wcnt[s] > 60) begin
               checks++; errors++;
               $display("FAIL grant side %0d: no grant within %0d cycles", s, wcnt[s]);
               set_req(s, 1'b0); ph[s] = 0;
            end
         end
         default: begin
            if (my_done) begin
               if (!my_req || $urandom_range(3) != 0) begin
                  set_req(s, 1'b0); ph[s] = 0; cool[s] = $urandom_range(2);
               end
            end else if (++wcnt[s] > 20) begin
               checks++; errors++;
               $display("FAIL done side %0d: done=0 after %0d cycles, expected 1", s, wcnt[s]);
               set_req(s, 1'b0); ph[s] = 0;
            end
         end
      endcase
   endtask

   initial begin
      axi_rst = 1'b0;
      set_side(0, 1'b0, 1'b0, '0, '0);
      set_side(1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      // Reset state
      repeat (2) cycle();
      chk("reset_en", 32'(en_BRAM), 32'd0);
      chk("reset_owner", 32'(owner), 32'd0);
      axi_rst = 1'b1;
      cycle();

      // AXI write 0x10 then read it back, with exact latencies
      set_side(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
      cycle();
      chk("wr_grant_busy", 32'(busy), 32'd1);
      chk("wr_grant_en", 32'(en_BRAM), 32'd0);
      cycle();
      chk("wr_en", 32'(en_BRAM), 32'd1);
      chk("wr_we", 32'(we_BRAM), 32'hF);
      chk("wr_addr", addr_BRAM, 32'h10);
      chk("wr_dout", dout_BRAM, 32'hCAFEF00D);
      chk("wr_done_early", 32'(axi_done), 32'd0);
      cycle();
      chk("wr_done", 32'(axi_done), 32'd1);
      set_req(0, 1'b0);
      cycle();
      chk("wr_done_clear", 32'(axi_done), 32'd0);
      chk("wr_idle", 32'(busy), 32'd0);
      set_side(0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      cycle();
      chk("rd_en", 32'(en_BRAM), 32'd1);
      chk("rd_we", 32'(we_BRAM), 32'h0);
      cycle();
      chk("rd_done_n2", 32'(axi_done), 32'd0);
      cycle();
      chk("rd_done_n3", 32'(axi_done), 32'd1);
      chk("rd_data", axi_rdata, 32'hCAFEF00D);
      set_req(0, 1'b0);
      cycle();

      // Simultaneous requests after reset: AXI first, AES right after AXI releases
      axi_rst = 1'b0;
      cycle();
      axi_rst = 1'b1;
      set_side(0, 1'b1, 1'b1, 32'h30, 32'h11111111);
      set_side(1, 1'b1, 1'b1, 32'h34, 32'h22222222);
      cycle();
      chk("tie_owner_axi", 32'(owner), 32'd0);
      wait_done(0);
      set_req(0, 1'b0);
      cycle();
      chk("tie_gap_busy", 32'(busy), 32'd0);
      cycle();
      chk("tie_owner_aes", 32'(owner), 32'd1);
      chk("tie_aes_busy", 32'(busy), 32'd1);
      wait_done(1);
      set_req(1, 1'b0);
      cycle();

      // Fairness: both keep asking; grants must alternate starting with AXI
      set_side(0, 1'b1, 1'b1, 32'h40, 32'h0000AAAA);
      set_side(1, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int i = 0; i < 6; i++) begin
         bit cur;
         wait_busy();
         chk("fair_owner", 32'(owner), 32'(i % 2));
         cur = owner;
         wait_done(cur);
         set_req(cur, 1'b0);
         if (i == 5) set_req(!cur, 1'b0);
         cycle();
         if (i != 5) set_req(cur, 1'b1);
      end

      // Isolation: AES read leaves AXI rdata/done alone
      do_txn(0, 1'b1, 32'h50, 32'hAAAA5555);
      do_txn(0, 1'b0, 32'h50, 32'h0);
      chk("iso_axi_pre", axi_rdata, 32'hAAAA5555);
      do_txn(1, 1'b1, 32'h20, 32'h12345678);
      set_side(1, 1'b1, 1'b0, 32'h20, 32'h0);
      wait_done(1);
      chk("iso_aes_rdata", aes_rdata, 32'h12345678);
      chk("iso_axi_rdata", axi_rdata, 32'hAAAA5555);
      chk("iso_axi_done", 32'(axi_done), 32'd0);
      set_req(1, 1'b0);
      cycle();

      // Command changes after the grant are ignored
      set_side(1, 1'b1, 1'b1, 32'h04, 32'h0BADBEEF);
      cycle();
      set_side(1, 1'b1, 1'b0, 32'h08, 32'hFFFFFFFF);
      cycle();
      chk("hold_addr", addr_BRAM, 32'h04);
      chk("hold_dout", dout_BRAM, 32'h0BADBEEF);
      chk("hold_we", 32'(we_BRAM), 32'hF);
      wait_done(1);
      set_req(1, 1'b0);
      cycle();
      do_txn(1, 1'b0, 32'h04, 32'h0);
      chk("hold_rdback", aes_rdata, 32'h0BADBEEF);
      do_txn(1, 1'b0, 32'h08, 32'h0);

      // Reset while the read is waiting on BRAM data
      set_side(0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      cycle();
      axi_rst = 1'b0;
      #1;
      chk("rstmid_en", 32'(en_BRAM), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_rdata", axi_rdata, 32'd0);
      chk("rstmid_addr", addr_BRAM, 32'd0);
      compare_all();
      set_req(0, 1'b0);
      cycle();
      axi_rst = 1'b1;
      cycle();
      cycle();
      chk("rstmid_no_done", 32'(axi_done), 32'd0);
      set_side(0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      cycle();
      cycle();
      chk("rst_rd_n2", 32'(axi_done), 32'd0);
      cycle();
      chk("rst_rd_n3", 32'(axi_done), 32'd1);
      chk("rst_rd_data", axi_rdata, 32'hCAFEF00D);
      set_req(0, 1'b0);
      cycle();

      // Randomized two-requester traffic
      for (int s = 0; s < 2; s++) begin
         ph[s] = 0; cool[s] = 0; wcnt[s] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 2; s++) agent_step(s == 1);
         cycle();
      end
      set_req(0, 1'b0);
      set_req(1, 1'b0);
      repeat (6) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
